cond_sum_abc_adder: RTL and testbench
=====================================

COND_SUM_ABC_ADDER -- requirements
Module: cond_sum_abc_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand/sum width; all requirements below use WIDTH=32.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  operands valid this cycle; capture enable.
REQ-005 mode  input  1  0 = two-operand add A+B+CIN; 1 = three-operand add A+B+C+CIN.
REQ-006 A  input  32  operand A (unsigned).
REQ-007 B  input  32  operand B (unsigned).
REQ-008 C  input  32  operand C (unsigned); ignored when mode=0.
REQ-009 CIN  input  1  carry-in, added at bit 0.
REQ-010 out_valid  output  1  S/CO hold a fresh result.
REQ-011 S  output  32  sum modulo 2^32.
REQ-012 CO  output  2  bits [33:32] of the exact sum.

Function
REQ-013 The block SHALL compute the exact sum E = A + B + (mode ? C : 0) + CIN as a 34-bit unsigned value; S = E[31:0], CO = E[33:32].
REQ-014 In mode 0, CO[1] SHALL always be 0 and CO[0] SHALL equal the carry out of bit 31.
REQ-015 Latency SHALL be exactly 1 cycle: on a rising edge with in_valid=1, S/CO SHALL load the result of the inputs present before that edge, and out_valid SHALL be 1 after that edge.
REQ-016 On a rising edge with in_valid=0, S and CO SHALL hold their previous values and out_valid SHALL be 0 after that edge.
REQ-017 Back-to-back in_valid=1 cycles SHALL produce one result per cycle with no stalls; there is no backpressure.
REQ-018 Arithmetic SHALL be unsigned; wrap-around beyond 2^34 cannot occur (max E = 3*(2^32-1)+1).
REQ-019 The combinational path from inputs to the output registers SHALL have no dependence on prior state.

Reset
REQ-020 While rst=1, S SHALL be 0, CO SHALL be 0 and out_valid SHALL be 0, independent of clk.
REQ-021 Reset asserted mid-operation SHALL discard any in-flight result; the first valid result after reset deassertion SHALL come from the first in_valid=1 edge with rst=0.

Structure
REQ-022 Three-operand path SHALL use one 3:2 carry-save (Wallace) layer: per-bit sum vector and carry vector (carry shifted left one bit); the carry shifted out of bit 31 SHALL contribute to CO.
REQ-023 The final carry-propagate add SHALL be a sub-module named cond_sum32: 32-bit conditional-sum adder (ports A, B, CIN, S, COUT) built from 4-bit blocks each precomputed for carry-in 0 and 1, selected by a carry mux tree.
REQ-024 In mode 0, cond_sum32 SHALL receive A and B directly; in mode 1, the carry-save sum and carry vectors; CIN feeds cond_sum32 CIN in both modes.
REQ-025 WIDTH default and the mode encoding constants (MODE_ADD2=0, MODE_ADD3=1) SHALL live in the shared package.

Verification
REQ-026 mode=0, A=FFFFFFFF, B=00000001, CIN=0, in_valid=1 -> next cycle S=00000000, CO=01, out_valid=1.
REQ-027 mode=1, A=B=C=FFFFFFFF, CIN=1 -> S=FFFFFFFE, CO=10.
REQ-028 mode=1, A=00001000, B=00000004, C=00000010, CIN=0 -> S=00001014, CO=00; mode=0 same operands -> S=00001004, CO=00 (C ignored).
REQ-029 mode=0, A=7FFFFFFF, B=00000001, CIN=1 on cycle n, then in_valid=0 on cycle n+1 with changed operands -> S=80000001, CO=00 at n+1, held at n+2 with out_valid=0.
REQ-030 Assert rst asynchronously between clock edges while in_valid=1 -> S=0, CO=0, out_valid=0 immediately; after deassertion, next in_valid=1 edge yields the correct sum.
REQ-031 Bench SHALL also check 10,000 random operand/mode/CIN vectors against a 34-bit reference sum.

Source files
------------

// File: rtl/cond_sum_abc_adder_pkg.sv
// Shared constants and helpers for the carry-save / conditional-sum adder.
// Holds the default operand width, the mode encoding and the carry-merge rule.
package cond_sum_abc_adder_pkg;

   localparam int CSA_WIDTH = 32;
   localparam int BLK_W     = 4;

   typedef enum logic {
      MODE_ADD2 = 1'b0,
      MODE_ADD3 = 1'b1
   } mode_e;

   // The two weight-2^WIDTH carries (CSA shift-out and CPA carry-out) add into CO.
   function automatic logic [1:0] merge_carries(input logic cpa_cout, input logic csa_cout);
      return {cpa_cout & csa_cout, cpa_cout ^ csa_cout};
   endfunction

endpackage

// File: rtl/cond_sum_abc_adder_cond_sum32.sv
// Conditional-sum carry-propagate adder: 4-bit blocks precomputed for both
// carry-ins, then merged pairwise by a log-depth carry mux tree.
module cond_sum32
   import cond_sum_abc_adder_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic [WIDTH-1:0] S,
   output logic             COUT
);

   localparam int NBLK   = WIDTH / BLK_W;
   localparam int LEVELS = $clog2(NBLK);

   logic [WIDTH-1:0] w_s0;
   logic [WIDTH-1:0] w_s1;
   logic [NBLK-1:0]  w_c0;
   logic [NBLK-1:0]  w_c1;
   logic             w_lo_c0;
   logic             w_lo_c1;
   logic             w_hi_c0;
   logic             w_hi_c1;
   logic             w_hi_s0;
   logic             w_hi_s1;

   always_comb begin
      w_s0    = '0;
      w_s1    = '0;
      w_c0    = '0;
      w_c1    = '0;
      w_lo_c0 = 1'b0;
      w_lo_c1 = 1'b0;
      w_hi_c0 = 1'b0;
      w_hi_c1 = 1'b0;
      w_hi_s0 = 1'b0;
      w_hi_s1 = 1'b0;

      for (int blk = 0; blk < NBLK; blk++) begin
         {w_c0[blk], w_s0[blk*BLK_W +: BLK_W]} =
            {1'b0, A[blk*BLK_W +: BLK_W]} + {1'b0, B[blk*BLK_W +: BLK_W]};
         {w_c1[blk], w_s1[blk*BLK_W +: BLK_W]} =
            {1'b0, A[blk*BLK_W +: BLK_W]} + {1'b0, B[blk*BLK_W +: BLK_W]} + 5'd1;
      end

      // Each level doubles the group size; group g is rebuilt in place from
      // groups 2g (low half) and 2g+1 (high half), so lower indices are free to overwrite.
      for (int lvl = 0; lvl < LEVELS; lvl++) begin
         for (int grp = 0; grp < (NBLK >> (lvl + 1)); grp++) begin
            w_lo_c0 = w_c0[2*grp];
            w_lo_c1 = w_c1[2*grp];
            w_hi_c0 = w_c0[2*grp+1];
            w_hi_c1 = w_c1[2*grp+1];
            for (int bit_i = 0; bit_i < WIDTH; bit_i++) begin
               if (bit_i / (BLK_W << lvl) == 2*grp + 1) begin
                  w_hi_s0     = w_s0[bit_i];
                  w_hi_s1     = w_s1[bit_i];
                  w_s0[bit_i] = w_lo_c0 ? w_hi_s1 : w_hi_s0;
                  w_s1[bit_i] = w_lo_c1 ? w_hi_s1 : w_hi_s0;
               end
            end
            w_c0[grp] = w_lo_c0 ? w_hi_c1 : w_hi_c0;
            w_c1[grp] = w_lo_c1 ? w_hi_c1 : w_hi_c0;
         end
      end
   end

   assign S    = CIN ? w_s1 : w_s0;
   assign COUT = CIN ? w_c1[0] : w_c0[0];

endmodule

// File: rtl/cond_sum_abc_adder.sv
// Two/three-operand unsigned adder: one 3:2 carry-save layer feeding a
// conditional-sum CPA, with a single registered output stage.
module cond_sum_abc_adder
   import cond_sum_abc_adder_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic             CIN,
   output logic             out_valid,
   output logic [WIDTH-1:0] S,
   output logic [1:0]       CO
);

   logic [WIDTH-1:0] w_csa_sum;
   logic [WIDTH-1:0] w_csa_cry;
   logic [WIDTH-1:0] w_csa_cry_sh;
   logic             w_csa_cout;
   logic             w_add3;
   logic [WIDTH-1:0] w_cpa_a;
   logic [WIDTH-1:0] w_cpa_b;
   logic [WIDTH-1:0] w_cpa_s;
   logic             w_cpa_cout;
   logic [1:0]       w_co;

   logic [WIDTH-1:0] r_s_p1;
   logic [1:0]       r_co_p1;
   logic             r_vld_p1;

   assign w_add3       = (mode == MODE_ADD3);
   assign w_csa_sum    = A ^ B ^ C;
   assign w_csa_cry    = (A & B) | (A & C) | (B & C);
   assign w_csa_cry_sh = {w_csa_cry[WIDTH-2:0], 1'b0};
   assign w_csa_cout   = w_csa_cry[WIDTH-1];

   assign w_cpa_a = w_add3 ? w_csa_sum    : A;
   assign w_cpa_b = w_add3 ? w_csa_cry_sh : B;

   cond_sum32 #(
      .WIDTH (WIDTH)
   ) u_cpa (
      .A    (w_cpa_a),
      .B    (w_cpa_b),
      .CIN  (CIN),
      .S    (w_cpa_s),
      .COUT (w_cpa_cout)
   );

   assign w_co = w_add3 ? merge_carries(w_cpa_cout, w_csa_cout) : {1'b0, w_cpa_cout};

   // p1: result register; data holds when no new operands arrive
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s_p1   <= '0;
         r_co_p1  <= '0;
         r_vld_p1 <= 1'b0;
      end else begin
         r_vld_p1 <= in_valid;
         if (in_valid) begin
            r_s_p1  <= w_cpa_s;
            r_co_p1 <= w_co;
         end
      end
   end

   assign S         = r_s_p1;
   assign CO        = r_co_p1;
   assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_cond_sum_abc_adder.sv
// Bench for cond_sum_abc_adder: directed table, hold/reset sequences and
// random vectors compared against a plain 34-bit arithmetic model.
module tb_cond_sum_abc_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        mode = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] c = '0;
   logic        cin = 1'b0;
   logic        out_valid;
   logic [31:0] s;
   logic [1:0]  co;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      string       name;
      logic        mode;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        cin;
      logic [31:0] es;
      logic [1:0]  eco;
   } vec_t;

   vec_t tbl[9];

   cond_sum_abc_adder #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .mode      (mode),
      .A         (a),
      .B         (b),
      .C         (c),
      .CIN       (cin),
      .out_valid (out_valid),
      .S         (s),
      .CO        (co)
   );

   always #5 clk = ~clk;

   function automatic logic [33:0] ref_sum(input logic m, input logic [31:0] x,
                                           input logic [31:0] y, input logic [31:0] z,
                                           input logic ci);
      logic [33:0] e;
      e = {2'b00, x} + {2'b00, y} + {33'd0, ci};
      if (m) e = e + {2'b00, z};
      return e;
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h0000_0000;
         2:       return 32'h8000_0000 | $urandom;
         3:       return 32'(1) << $urandom_range(0, 31);
         default: return $urandom;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic m, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] z, input logic ci);
      in_valid = v;
      mode     = m;
      a        = x;
      b        = y;
      c        = z;
      cin      = ci;
   endtask

   task automatic chk(input string name, input logic [31:0] es, input logic [1:0] eco,
                      input logic ev);
      n_chk++;
      if (s !== es || co !== eco || out_valid !== ev) begin
         n_err++;
         $display("FAIL %s: got S=%08h CO=%02b out_valid=%0b, want S=%08h CO=%02b out_valid=%0b",
                  name, s, co, out_valid, es, eco, ev);
      end
   endtask

   initial begin
      logic [33:0] e;
      logic [31:0] es;
      logic [1:0]  eco;
      logic        ev;
      int          nvalid;

      tbl[0] = '{"add2_wrap",      1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000, 2'b01};
      tbl[1] = '{"add3_all_ones",  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 2'b10};
      tbl[2] = '{"add3_small",     1'b1, 32'h0000_1000, 32'h0000_0004, 32'h0000_0010, 1'b0, 32'h0000_1014, 2'b00};
      tbl[3] = '{"add2_ignore_c",  1'b0, 32'h0000_1000, 32'h0000_0004, 32'h0000_0010, 1'b0, 32'h0000_1004, 2'b00};
      tbl[4] = '{"add2_max_cin",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 2'b01};
      tbl[5] = '{"add3_msb_pair",  1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 2'b01};
      tbl[6] = '{"add3_msb_tri",   1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_0001, 2'b01};
      tbl[7] = '{"add2_cin_only",  1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 2'b00};
      tbl[8] = '{"add3_long_chain",1'b1, 32'h0000_FFFF, 32'h0000_0001, 32'hFFFF_0000, 1'b0, 32'h0000_0000, 2'b01};

      // Reset held across an edge with valid operands present
      drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      step();
      chk("reset_state", 32'h0, 2'b00, 1'b0);
      rst = 1'b0;
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
      step();
      chk("idle_after_reset", 32'h0, 2'b00, 1'b0);

      for (int i = 0; i < 9; i++) begin
         drive(1'b1, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].cin);
         step();
         chk(tbl[i].name, tbl[i].es, tbl[i].eco, 1'b1);
         drive(1'b0, ~tbl[i].mode, $urandom, $urandom, $urandom, ~tbl[i].cin);
         step();
         chk({tbl[i].name, "_hold"}, tbl[i].es, tbl[i].eco, 1'b0);
      end

      // Result then an idle cycle with changed operands
      drive(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
      step();
      chk("seq_load", 32'h8000_0001, 2'b00, 1'b1);
      drive(1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1'b0);
      step();
      chk("seq_hold", 32'h8000_0001, 2'b00, 1'b0);

      // Asynchronous reset between edges while valid is asserted
      drive(1'b1, 1'b1, 32'h1234_5678, 32'h1111_1111, 32'h0000_0001, 1'b0);
      step();
      e = ref_sum(1'b1, 32'h1234_5678, 32'h1111_1111, 32'h0000_0001, 1'b0);
      chk("pre_reset", e[31:0], e[33:32], 1'b1);
      drive(1'b1, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      chk("async_reset", 32'h0, 2'b00, 1'b0);
      step();
      chk("reset_held_edge", 32'h0, 2'b00, 1'b0);
      rst = 1'b0;
      drive(1'b1, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0, 1'b1);
      step();
      e = ref_sum(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0, 1'b1);
      chk("post_reset", e[31:0], e[33:32], 1'b1);

      // Random traffic with occasional idle cycles
      es     = e[31:0];
      eco    = e[33:32];
      nvalid = 0;
      while (nvalid < 10000) begin
         ev = ($urandom_range(0, 7) != 0);
         drive(ev, 1'($urandom_range(0, 1)), rnd_op(), rnd_op(), rnd_op(),
               1'($urandom_range(0, 1)));
         e = ref_sum(mode, a, b, c, cin);
         step();
         if (ev) begin
            es  = e[31:0];
            eco = e[33:32];
            nvalid++;
         end
         chk("random", es, eco, ev);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
